// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED scan driver: digit count, the 7-bit
// active-low segment vector {a,b,c,d,e,f,g} and its sixteen hex glyphs.
package led_scan_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'b0000001;
  localparam seg_t SEG_1   = 7'b1001111;
  localparam seg_t SEG_2   = 7'b0010010;
  localparam seg_t SEG_3   = 7'b0000110;
  localparam seg_t SEG_4   = 7'b1001100;
  localparam seg_t SEG_5   = 7'b0100100;
  localparam seg_t SEG_6   = 7'b0100000;
  localparam seg_t SEG_7   = 7'b0001111;
  localparam seg_t SEG_8   = 7'b0000000;
  localparam seg_t SEG_9   = 7'b0000100;
  localparam seg_t SEG_A   = 7'b0001000;
  localparam seg_t SEG_B   = 7'b1100000;
  localparam seg_t SEG_C   = 7'b0110001;
  localparam seg_t SEG_D   = 7'b1000010;
  localparam seg_t SEG_E   = 7'b0110000;
  localparam seg_t SEG_F   = 7'b0111000;
  localparam seg_t SEG_OFF = 7'b1111111;

  localparam logic [7:0] ANODES_OFF = 8'hFF;

endpackage

// File: rtl/led_scan_driver_if.sv
// Display bus between the datapath (master) and the scan driver (slave):
// the word and decimal points to show, plus the board-level display pins.
interface led_scan_driver_if;

  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  Anodes;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        e;
  logic        f;
  logic        g;
  logic        dp;

  modport master (
    output data_in, dp_in,
    input  Anodes, a, b, c, d, e, f, g, dp
  );

  modport slave (
    input  data_in, dp_in,
    output Anodes, a, b, c, d, e, f, g, dp
  );

endinterface

// File: rtl/led_scan_driver_hex_to_7seg.sv
// Combinational hex nibble to active-low {a..g} glyph decoder.
module hex_to_7seg
  import led_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  // Glyph lookup
  always_comb begin
    case (nibble_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      4'hF:    seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/led_scan_driver.sv
// Eight-digit common-anode hex scan driver with frame-synchronous shadowing
// and anti-ghost blanking; define LZ_BLANK_EN for leading-zero suppression.
module led_scan_driver
  import led_scan_pkg::*;
#(
  parameter int TICK_COUNT   = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  led_scan_driver_if.slave  bus
);

  localparam int CNT_W = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_COUNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_data_q, shadow_data_d;
  logic [7:0]       shadow_dp_q, shadow_dp_d;
  logic [7:0]       anodes_q, anodes_d;
  seg_t             seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tc_s;
  logic [3:0]       nibble_s;
  seg_t             glyph_s;
  logic [7:0]       lz_off_s;

  assign tc_s     = (cnt_q == CNT_LAST);
  assign nibble_s = shadow_data_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nibble_i (nibble_s),
    .seg_o    (glyph_s)
  );

`ifdef LZ_BLANK_EN
  // Digits whose nibble and all more-significant nibbles are zero stay dark unless their point is lit
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_off_s   = 8'h00;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above  = zero_above & (shadow_data_q[4*k +: 4] == 4'h0);
      lz_off_s[k] = zero_above & ~shadow_dp_q[k];
    end
  end
`else
  assign lz_off_s = 8'h00;
`endif

  // Prescaler, digit index and frame-boundary shadow capture
  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    if (tc_s) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        shadow_data_d = bus.data_in;
        shadow_dp_d   = bus.dp_in;
      end else begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // Next values of the display pins
  always_comb begin
    anodes_d = ANODES_OFF;
    seg_d    = glyph_s;
    dp_d     = ~shadow_dp_q[idx_q];
    if (cnt_q < BLANK_LIM) begin
      anodes_d = ANODES_OFF;
    end else begin
      anodes_d = ~(8'b0000_0001 << idx_q) | lz_off_s;
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shadow_data_q <= 32'h0000_0000;
      shadow_dp_q   <= 8'h00;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
    end
  end

  // Registered display pins so the board sees glitch-free drives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anodes_q <= ANODES_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      anodes_q <= anodes_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.Anodes = anodes_q;
  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;
  assign bus.dp     = dp_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with TICK_COUNT=8, BLANK_CYCLES=2;
// edge numbers count rising clock edges since the last reset release.
module tb_led_scan_driver;

  localparam int TC = 8;
  localparam int BC = 2;
`ifdef LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   e     = 0;

  led_scan_driver_if bus ();

  led_scan_driver #(.TICK_COUNT(TC), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic goto_edge(input int target);
    while (e < target) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] an, input logic [6:0] seg, input logic dp);
    logic [15:0] o;
    logic [15:0] x;
    o = {bus.Anodes, bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.dp};
    x = {an, seg, dp};
    n_cmp++;
    assert (o === x) else begin
      n_err++;
      $error("FAIL %s: observed an/seg/dp=%h expected %h", tag, o, x);
    end
  endtask

  task automatic chk_an(input string tag, input logic [7:0] an);
    n_cmp++;
    assert (bus.Anodes === an) else begin
      n_err++;
      $error("FAIL %s: observed Anodes=%h expected %h", tag, bus.Anodes, an);
    end
  endtask

  // Checks Anodes on every edge of one frame; lit marks digits expected to light
  task automatic scan_frame(input int first, input logic [7:0] lit);
    int         cnt;
    int         idx;
    logic [7:0] x;
    goto_edge(first - 1);
    for (int i = 0; i < 8 * TC; i++) begin
      goto_edge(e + 1);
      cnt = (e - 1) % TC;
      idx = ((e - 1) / TC) % 8;
      x   = ~(8'h01 << idx);
      if (cnt < BC || !lit[idx]) x = 8'hFF;
      chk_an($sformatf("scan_e%0d", e), x);
    end
  endtask

  initial begin
    bus.data_in = 32'h0000_0000;
    bus.dp_in   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 8'hFF, 7'h7F, 1'b1);

    reset = 1'b1;
    e = 0;
    goto_edge(1);  chk("rel_e1", 8'hFF, 7'h01, 1'b1);
    goto_edge(2);  chk("rel_e2", 8'hFF, 7'h01, 1'b1);
    goto_edge(3);  chk("rel_digit0_lit", 8'hFE, 7'h01, 1'b1);
    goto_edge(8);  chk("rel_digit0_end", 8'hFE, 7'h01, 1'b1);
    goto_edge(9);  chk("rel_digit1_blank", 8'hFF, 7'h01, 1'b1);
    goto_edge(11); chk("rel_digit1", LZ ? 8'hFF : 8'hFD, 7'h01, 1'b1);

    bus.data_in = 32'h1234_ABCD;
    goto_edge(66);  chk("load_blank_seg", 8'hFF, 7'h42, 1'b1);
    goto_edge(67);  chk("load_digit0", 8'hFE, 7'h42, 1'b1);
    goto_edge(75);  chk("load_digit1", 8'hFD, 7'h31, 1'b1);
    goto_edge(83);  chk("load_digit2", 8'hFB, 7'h60, 1'b1);
    goto_edge(91);  chk("load_digit3", 8'hF7, 7'h08, 1'b1);
    goto_edge(99);  chk("load_digit4", 8'hEF, 7'h4C, 1'b1);
    goto_edge(123); chk("load_digit7", 8'h7F, 7'h4F, 1'b1);

    goto_edge(155); chk("tear_digit3", 8'hF7, 7'h08, 1'b1);
    bus.data_in = 32'hFFFF_FFFF;
    bus.dp_in   = 8'h05;
    goto_edge(163); chk("tear_digit4_old", 8'hEF, 7'h4C, 1'b1);
    goto_edge(171); chk("tear_digit5_old", 8'hDF, 7'h06, 1'b1);
    goto_edge(187); chk("tear_digit7_old", 8'h7F, 7'h4F, 1'b1);
    goto_edge(195); chk("tear_digit0_new", 8'hFE, 7'h38, 1'b0);
    goto_edge(203); chk("tear_digit1_new", 8'hFD, 7'h38, 1'b1);
    goto_edge(211); chk("tear_digit2_new", 8'hFB, 7'h38, 1'b0);

    scan_frame(257, 8'hFF);
    scan_frame(321, 8'hFF);

    goto_edge(427); chk("mid_digit5", 8'hDF, 7'h38, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_reset_async", 8'hFF, 7'h7F, 1'b1);
    @(posedge clk);
    #1;
    chk("mid_reset_hold", 8'hFF, 7'h7F, 1'b1);
    reset = 1'b1;
    e = 0;
    goto_edge(3);  chk("restart_digit0", 8'hFE, 7'h01, 1'b1);
    goto_edge(11); chk("restart_digit1", LZ ? 8'hFF : 8'hFD, 7'h01, 1'b1);
    goto_edge(67); chk("restart_load", 8'hFE, 7'h38, 1'b0);

`ifdef LZ_BLANK_EN
    bus.data_in = 32'h0000_00A5;
    bus.dp_in   = 8'h00;
    goto_edge(131); chk("lz_a5_digit0", 8'hFE, 7'h24, 1'b1);
    goto_edge(139); chk("lz_a5_digit1", 8'hFD, 7'h08, 1'b1);
    scan_frame(193, 8'h03);
    bus.data_in = 32'h0000_0000;
    goto_edge(323); chk("lz_zero_digit0", 8'hFE, 7'h01, 1'b1);
    scan_frame(385, 8'h01);
    bus.dp_in = 8'h80;
    goto_edge(571); chk("lz_dp_digit7", 8'h7F, 7'h01, 1'b0);
    scan_frame(577, 8'h81);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Downstream display stage for the integer datapath: takes the 32-bit word formed as {Reg_Out, Alu_Out} and time-multiplexes it as eight hex digits onto the board's common-anode 7-segment display. It has a refresh prescaler, a digit-scan counter and a frame-synchronous shadow register, so the display never shows a value that is half old and half new. It adds a short anti-ghosting blank at each digit change. All outputs are registered.

## Interface
- TICK_COUNT, 100000: clk cycles per digit period (1 kHz digit rate, 125 Hz frame rate at 100 MHz); legal range 2..2^20.
- BLANK_CYCLES, 4: cycles at the start of each digit period during which all anodes are off; legal range 0..TICK_COUNT-1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  32  value to display; nibble k drives digit k, with digit 0 rightmost.
- dp_in  in  8  decimal point enables, active-high; bit k goes to digit k.
- Anodes  out  8  digit enables, active-low; bit k selects digit k.
- a, b, c, d, e, f, g  out  1 each  segment drives, active-low.
- dp  out  1  decimal point drive, active-low.

## Operation
- Prescaler `cnt`:
  - Counts 0..TICK_COUNT-1 and wraps to 0.
  - A terminal count (tc) is `cnt==TICK_COUNT-1`.
- Digit index `idx` (3 bits):
  - Increments on tc, wrapping 7→0.
  - Stays at 0 out of reset.
- Shadow registers `shadow_data` (32 bits) and `shadow_dp` (8 bits):
  - Load data_in/dp_in on tc when idx==7, which is the frame boundary.
  - Hold their value at all other times.
  - Reset value is 0, so the first frame after reset shows "00000000" with no decimal points.
- Per-cycle next-state values of the registered outputs:
  - Anodes = 8'hFF if cnt < BLANK_CYCLES, else ~(8'b1 << idx).
  - {a..g} = hex pattern of shadow_data[4*idx+3 : 4*idx].
  - dp = ~shadow_dp[idx].
- Hex patterns, written {a,b,c,d,e,f,g}, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Values of data_in that change mid-frame have no visible effect until the next frame boundary.
- Reset asserted at any point, including mid-frame, immediately forces:
  - cnt=0, idx=0, shadows=0
  - Anodes=8'hFF, segments=1111111, dp=1

## Timing
- Reset values: Anodes=8'hFF, a..g=1, dp=1.
- Output latency: one cycle. Outputs at cycle t+1 reflect cnt, idx and shadow at cycle t.
- Digit period: exactly TICK_COUNT cycles. Of these, the digit is lit for TICK_COUNT-BLANK_CYCLES cycles.
- Frame period: 8*TICK_COUNT cycles.
- Data capture: data_in is sampled on the single cycle with idx==7 and tc. It appears on digit 0 one cycle after cnt returns to 0, or BLANK_CYCLES+1 cycles after it if blanking is enabled.
- BLANK_CYCLES=0: no blanking; Anodes switches directly from one digit to the next.
- After reset release, digit 0 lights at cycle BLANK_CYCLES+1.

## Configuration
- LZ_BLANK_EN defined: leading-zero suppression.
  - A digit k > 0 has its anode held off (bit k = 1) when shadow_data nibbles 7..k are all zero.
  - Digit 0 is always shown.
  - dp_in still forces the anode on for its digit, so that the point stays visible.
- LZ_BLANK_EN undefined: all eight digits are always scanned.

## Structure
- Package led_scan_pkg holds:
  - NUM_DIGITS = 8
  - the 16 segment pattern constants
  - the 7-bit segment vector typedef
- One sub-module, hex_to_7seg: a combinational 4-bit → 7-bit decoder built from the package constants.
- Prescaler, index, shadow registers and output registers all live in led_scan_driver.

## Test plan
All scenarios use TICK_COUNT=8 and BLANK_CYCLES=2.
- Reset: hold reset low → Anodes=FF, {a..g}=1111111, dp=1. Release → digit 0 shows pattern 0000001 with Anodes=FE at cycle 3.
- Load: data_in=32'h1234ABCD, held across one frame boundary. Next frame →
  - digit 0: Anodes=FE, segments 1000010 (d)
  - digit 4: Anodes=EF, segments 1001100 (4)
  - digit 7: Anodes=7F, segments 1001111 (1)
- Tearing: change data_in to 32'hFFFFFFFF while idx=3 → digits 4–7 still show the old value. All digits show F only after the 7→0 wrap.
- Blanking: in every digit period, Anodes=FF for the first 2 cycles, then one-hot low for 6 cycles. Check over 16 consecutive periods.
- LZ_BLANK_EN: data_in=32'h000000A5 → only Anodes FE and FD are ever active, and digits 2–7 stay FF. data_in=0 → only digit 0 lights, showing 0000001. dp_in=8'h80 → digit 7 lights with dp=0.
- Mid-frame reset: assert reset while idx=5 → outputs go to reset values within the same cycle. After release, the scan restarts at digit 0 showing 0.
